// File: rtl/pipe_stall_ctrl_if.sv
// Handshake bundle between the hazard/decode/EX side and the stall controller.
// Perf counter signals exist only when PIPE_STALL_PERF_EN is defined.
interface pipe_stall_ctrl_if
`ifdef PIPE_STALL_PERF_EN
    #(parameter int CNT_W = 16)
`endif
    ;
    logic       hazard;
    logic       call;
    logic       ret;
    logic       PC_update;
    logic       branch_taken;
    logic       stall_PC;
    logic       stall_IF_ID;
    logic       flush_IF_ID;
    logic       bubble_ID_EX;
    logic [1:0] state;
    logic       stall_err;
`ifdef PIPE_STALL_PERF_EN
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;
`endif

    modport master (
        output hazard, call, ret, PC_update, branch_taken,
        input  stall_PC, stall_IF_ID, flush_IF_ID, bubble_ID_EX, state, stall_err
`ifdef PIPE_STALL_PERF_EN
        , input stall_cycles, flush_count
`endif
    );

    modport slave (
        input  hazard, call, ret, PC_update, branch_taken,
        output stall_PC, stall_IF_ID, flush_IF_ID, bubble_ID_EX, state, stall_err
`ifdef PIPE_STALL_PERF_EN
        , output stall_cycles, flush_count
`endif
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush sequencer: data stalls, call/ret halt window, branch flush.
// Optional perf counters are enabled with the PIPE_STALL_PERF_EN macro.
module pipe_stall_ctrl #(
    parameter int MAX_DATA_STALL = 3
`ifdef PIPE_STALL_PERF_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic            clk,
    input  logic            rst,
    pipe_stall_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        RUN    = 2'b00,
        DSTALL = 2'b01,
        CHALT  = 2'b10,
        FLUSH  = 2'b11
    } state_t;

    localparam logic [3:0] MAX_CNT = MAX_DATA_STALL[3:0];

    state_t     cur_state, next_state;
    logic [3:0] scnt, scnt_nxt;
    logic       err_q, err_nxt;
    logic       stall_pc_c, stall_ifid_c, flush_ifid_c, bubble_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= RUN;
            scnt      <= '0;
            err_q     <= 1'b0;
        end else begin
            cur_state <= next_state;
            scnt      <= scnt_nxt;
            err_q     <= err_nxt;
        end
    end

    // Priority is branch > hazard > call/ret; the branch squashes everything younger.
    always_comb begin
        next_state   = cur_state;
        scnt_nxt     = scnt;
        err_nxt      = err_q;
        stall_pc_c   = 1'b0;
        stall_ifid_c = 1'b0;
        flush_ifid_c = 1'b0;
        bubble_c     = 1'b0;
        if (bus.branch_taken) begin
            flush_ifid_c = 1'b1;
            bubble_c     = 1'b1;
            next_state   = FLUSH;
            scnt_nxt     = '0;
        end else begin
            case (cur_state)
                RUN, DSTALL: begin
                    if (bus.hazard) begin
                        stall_pc_c   = 1'b1;
                        stall_ifid_c = 1'b1;
                        bubble_c     = 1'b1;
                        next_state   = DSTALL;
                        scnt_nxt     = (scnt == 4'hF) ? scnt : scnt + 4'd1;
                        if (scnt == MAX_CNT) begin
                            err_nxt = 1'b1;
                        end
                    end else begin
                        scnt_nxt = '0;
                        if (bus.call || bus.ret) begin
                            stall_pc_c   = 1'b1;
                            flush_ifid_c = 1'b1;
                            next_state   = CHALT;
                        end else begin
                            next_state = RUN;
                        end
                    end
                end
                CHALT: begin
                    if (bus.PC_update) begin
                        next_state = RUN;
                    end else begin
                        stall_pc_c   = 1'b1;
                        flush_ifid_c = 1'b1;
                    end
                end
                FLUSH: begin
                    flush_ifid_c = 1'b1;
                    next_state   = RUN;
                end
                default: next_state = RUN;
            endcase
        end
    end

    assign bus.stall_PC     = stall_pc_c;
    assign bus.stall_IF_ID  = stall_ifid_c;
    assign bus.flush_IF_ID  = flush_ifid_c;
    assign bus.bubble_ID_EX = bubble_c;
    assign bus.state        = cur_state;
    assign bus.stall_err    = err_q;

`ifdef PIPE_STALL_PERF_EN
    logic [CNT_W-1:0] stall_cycles_q, flush_count_q;

    // Both counters saturate rather than wrap so long runs stay meaningful.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (stall_pc_c && (stall_cycles_q != '1)) begin
                stall_cycles_q <= stall_cycles_q + 1'b1;
            end
            if (bus.branch_taken && (flush_count_q != '1)) begin
                flush_count_q <= flush_count_q + 1'b1;
            end
        end
    end

    assign bus.stall_cycles = stall_cycles_q;
    assign bus.flush_count  = flush_count_q;
`endif
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: a driver predicts each cycle's response with
// a behavioural model and queues it; a monitor pops and compares on the falling edge.
module tb_pipe_stall_ctrl;
    localparam int MAXDS    = 3;
    localparam int TB_CNT_W = 16;
    localparam int unsigned CNT_MAX = (1 << TB_CNT_W) - 1;

    typedef struct packed {
        bit          chk;
        logic        s_pc;
        logic        s_ifid;
        logic        fl;
        logic        bub;
        logic [1:0]  st;
        logic        err;
        int unsigned sc;
        int unsigned fc;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sb[$];
    exp_t mon_e;
    int   tests;
    int   failures;

    // Model: facts about the pipeline rather than an encoded state.
    bit          m_halt;
    bit          m_flush;
    int          m_run;
    bit          m_err;
    int unsigned m_sc;
    int unsigned m_fc;

`ifdef PIPE_STALL_PERF_EN
    pipe_stall_ctrl_if #(.CNT_W(TB_CNT_W)) bus ();
    pipe_stall_ctrl #(.MAX_DATA_STALL(MAXDS), .CNT_W(TB_CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );
`else
    pipe_stall_ctrl_if bus ();
    pipe_stall_ctrl #(.MAX_DATA_STALL(MAXDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // One cycle: drive inputs just after the edge, queue the predicted response, advance the model.
    task automatic applyStimulus(input bit r, input bit h, input bit c, input bit rt,
                                 input bit pu, input bit b);
        exp_t e;
        @(posedge clk);
        #1;
        rst              = r;
        bus.hazard       = h;
        bus.call         = c;
        bus.ret          = rt;
        bus.PC_update    = pu;
        bus.branch_taken = b;
        e        = '0;
        e.chk    = !r;
        e.st     = m_halt ? 2'b10 : (m_flush ? 2'b11 : ((m_run > 0) ? 2'b01 : 2'b00));
        e.err    = m_err;
        e.sc     = m_sc;
        e.fc     = m_fc;
        if (r) begin
            m_halt = 0; m_flush = 0; m_run = 0; m_err = 0; m_sc = 0; m_fc = 0;
        end else begin
            if (b) begin
                e.fl = 1; e.bub = 1;
                m_flush = 1; m_halt = 0; m_run = 0;
                if (m_fc != CNT_MAX) m_fc++;
            end else if (m_halt) begin
                if (pu) m_halt = 0;
                else begin e.s_pc = 1; e.fl = 1; end
            end else if (m_flush) begin
                e.fl = 1;
                m_flush = 0;
            end else if (h) begin
                e.s_pc = 1; e.s_ifid = 1; e.bub = 1;
                if (m_run == MAXDS) m_err = 1;
                m_run++;
            end else if (c || rt) begin
                e.s_pc = 1; e.fl = 1;
                m_halt = 1; m_run = 0;
            end else begin
                m_run = 0;
            end
            if (e.s_pc && m_sc != CNT_MAX) m_sc++;
        end
        sb.push_back(e);
    endtask

    // Monitor: compares every queued cycle on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                if (mon_e.chk) begin
                    checkOutput("stall_PC",     32'(bus.stall_PC),     32'(mon_e.s_pc));
                    checkOutput("stall_IF_ID",  32'(bus.stall_IF_ID),  32'(mon_e.s_ifid));
                    checkOutput("flush_IF_ID",  32'(bus.flush_IF_ID),  32'(mon_e.fl));
                    checkOutput("bubble_ID_EX", 32'(bus.bubble_ID_EX), 32'(mon_e.bub));
                    checkOutput("state",        32'(bus.state),        32'(mon_e.st));
                    checkOutput("stall_err",    32'(bus.stall_err),    32'(mon_e.err));
`ifdef PIPE_STALL_PERF_EN
                    checkOutput("stall_cycles", 32'(bus.stall_cycles), mon_e.sc);
                    checkOutput("flush_count",  32'(bus.flush_count),  mon_e.fc);
`endif
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        tests = 0; failures = 0;
        m_halt = 0; m_flush = 0; m_run = 0; m_err = 0; m_sc = 0; m_fc = 0;
        rst = 1'b1;
        bus.hazard = 0; bus.call = 0; bus.ret = 0; bus.PC_update = 0; bus.branch_taken = 0;

        repeat (2) applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        // Two-cycle data stall
        repeat (2) applyStimulus(0, 1, 0, 0, 0, 0);
        repeat (2) applyStimulus(0, 0, 0, 0, 0, 0);

        // Call halt window closed by PC_update on the fifth cycle
        applyStimulus(0, 0, 1, 0, 0, 0);
        repeat (3) applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        // Long stall trips the sticky error
        repeat (5) applyStimulus(0, 1, 0, 0, 0, 0);
        repeat (2) applyStimulus(0, 0, 0, 0, 0, 0);

        // Branch abandons a ret halt
        applyStimulus(0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        repeat (2) applyStimulus(0, 0, 0, 0, 0, 0);

        // Priority: branch over hazard over call
        applyStimulus(0, 1, 1, 0, 0, 1);
        repeat (2) applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        // Reset in the middle of a halt and of a stall
        applyStimulus(0, 0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        repeat (2) applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        // Randomized traffic with bursty hazards
        for (int i = 0; i < 3000; i++) begin
            bit h;
            h = ($urandom_range(0, 99) < ((i % 64) < 16 ? 85 : 30));
            applyStimulus($urandom_range(0, 199) == 0, h,
                          $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 15,
                          $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 10);
        end
        applyStimulus(0, 0, 0, 0, 0, 0);

        repeat (5) @(negedge clk);
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
